// File: rtl/fiapp_mon_pkg.sv
// Shared types for the fiapp response monitor: FSM states, mismatch mask, history record.
// No logic; latency and backpressure not applicable.
package fiapp_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    typedef logic [2:0] mask_t;

    localparam int O4_W    = 65;
    localparam int STAMP_W = 32;

    typedef struct packed {
        logic [STAMP_W-1:0] stamp;
        mask_t              mask;
    } hist_rec_t;

endpackage

// File: rtl/fiapp_mon_hist_fifo.sv
// Mismatch history FIFO; data visible one cycle after push, push+pop allowed when full.
// No upstream backpressure: a push into a full FIFO without a pop is dropped and flagged in ovf.
module fiapp_mon_hist_fifo #(
    parameter int W = 35,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         ovf
);
    localparam int AW = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign full    = (count == (AW+1)'(D));
    assign valid   = (count != '0);
    assign data    = valid ? mem[rd_ptr] : '0;
    assign do_pop  = pop && valid && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && full && !do_pop)
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/fiapp_response_monitor.sv
// Golden shadow of the fiapp target; compares o1/o2/o4 same-cycle (zero latency) and records faults.
// No backpressure on the target side; history (FIAPP_MON_HISTORY_EN) is popped via hist_valid_o/hist_ready_i.
module fiapp_response_monitor
    import fiapp_mon_pkg::*;
#(
    parameter int CYC_W  = 32,
    parameter int CNT_W  = 16,
    parameter int HIST_D = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mon_a,
    input  logic              mon_enable,
    input  logic              dut_o1,
    input  logic              dut_o2,
    input  logic              dut_o3,
    input  logic [O4_W-1:0]   dut_o4,
    input  logic              arm,
    input  logic              disarm,
    input  logic              clr,
    output logic [1:0]        state_o,
    output logic              fault_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [CYC_W-1:0]  first_cyc_o,
    output logic [2:0]        first_mask_o,
    output logic              hist_valid_o,
    input  logic              hist_ready_i,
    output logic [CYC_W+2:0]  hist_data_o,
    output logic              hist_ovf_o
);
    state_t            state;
    logic              s_q1;
    logic              s_q2;
    logic              s_q3;
    logic [O4_W-1:0]   s_o4;
    logic [CYC_W-1:0]  cyc;
    mask_t             mask;
    logic              mm;
    logic              take_clr;
    logic              take_arm;
    logic              count_mm;

    assign state_o  = state;
    assign mask     = {dut_o4 != s_o4, dut_o2 != s_q2, dut_o1 != s_q1};
    assign mm       = |mask;
    assign take_clr = clr && !disarm;
    assign take_arm = arm && !disarm && !clr && (state == ST_IDLE);
    assign count_mm = mm && !disarm && !clr && (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            s_q1         <= 1'b0;
            s_q2         <= 1'b0;
            s_q3         <= 1'b0;
            s_o4         <= '0;
            cyc          <= '0;
            fault_o      <= 1'b0;
            err_cnt_o    <= '0;
            first_cyc_o  <= '0;
            first_mask_o <= '0;
        end else begin
            s_q1 <= mon_enable ? mon_a : s_q1;
            s_q2 <= s_q1;
            s_q3 <= !s_q1;
            s_o4 <= {s_o4[O4_W-2:0], mon_a};

            if (state != ST_IDLE && cyc != '1)
                cyc <= cyc + CYC_W'(1);

            if (disarm) begin
                state <= ST_IDLE;
            end else if (take_clr) begin
                // A mismatch in the same cycle as clr is deliberately discarded.
                if (state != ST_IDLE)
                    state <= ST_TRACK;
                fault_o      <= 1'b0;
                err_cnt_o    <= '0;
                first_cyc_o  <= '0;
                first_mask_o <= '0;
            end else if (take_arm) begin
                state        <= ST_TRACK;
                cyc          <= '0;
                fault_o      <= 1'b0;
                err_cnt_o    <= '0;
                first_cyc_o  <= '0;
                first_mask_o <= '0;
            end else if (count_mm && state == ST_TRACK) begin
                state        <= ST_FAULT;
                fault_o      <= 1'b1;
                err_cnt_o    <= CNT_W'(1);
                first_cyc_o  <= cyc;
                first_mask_o <= mask;
            end else if (count_mm && state == ST_FAULT) begin
                if (err_cnt_o != '1)
                    err_cnt_o <= err_cnt_o + CNT_W'(1);
            end
        end
    end

`ifdef FIAPP_MON_HISTORY_EN
    logic unused_ok;
    assign unused_ok = ^{dut_o3, s_q3};

    fiapp_mon_hist_fifo #(
        .W (CYC_W + 3),
        .D (HIST_D)
    ) u_hist (
        .clk       (clk),
        .reset     (reset),
        .flush     (take_clr || take_arm),
        .push      (count_mm),
        .push_data ({cyc, mask}),
        .pop       (hist_valid_o && hist_ready_i),
        .valid     (hist_valid_o),
        .data      (hist_data_o),
        .ovf       (hist_ovf_o)
    );
`else
    logic unused_ok;
    assign unused_ok    = ^{dut_o3, s_q3, hist_ready_i, HIST_D[0]};
    assign hist_valid_o = 1'b0;
    assign hist_data_o  = '0;
    assign hist_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_fiapp_response_monitor.sv
// Self-checking bench: behavioural fiapp target with fault injection, scoreboard of expected monitor outputs.
module tb_fiapp_response_monitor;
    import fiapp_mon_pkg::*;

    localparam int CYC_W  = 32;
    localparam int CNT_W  = 4;
    localparam int HIST_D = 4;

    localparam int SIG_STATE = 0;
    localparam int SIG_FAULT = 1;
    localparam int SIG_ERR   = 2;
    localparam int SIG_FCYC  = 3;
    localparam int SIG_FMASK = 4;
    localparam int SIG_HVLD  = 5;
    localparam int SIG_HOVF  = 6;
    localparam int SIG_HDAT  = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic a = 1'b0;
    logic enable = 1'b0;
    logic arm = 1'b0;
    logic disarm = 1'b0;
    logic clr = 1'b0;
    logic hist_ready = 1'b0;
    logic f1 = 1'b0;
    logic f2 = 1'b0;
    logic f4 = 1'b0;

    logic        t_q1;
    logic        t_q2;
    logic        t_q3;
    logic [64:0] t_o4;

    logic              dut_o1;
    logic              dut_o2;
    logic              dut_o3;
    logic [64:0]       dut_o4;
    logic [1:0]        state_o;
    logic              fault_o;
    logic [CNT_W-1:0]  err_cnt_o;
    logic [CYC_W-1:0]  first_cyc_o;
    logic [2:0]        first_mask_o;
    logic              hist_valid_o;
    logic [CYC_W+2:0]  hist_data_o;
    logic              hist_ovf_o;

    always #5 clk = ~clk;

    // Behavioural fiapp target; faults are injected on its outputs only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_q1 <= 1'b0;
            t_q2 <= 1'b0;
            t_q3 <= 1'b0;
            t_o4 <= '0;
        end else begin
            t_q1 <= enable ? a : t_q1;
            t_q2 <= t_q1;
            t_q3 <= !t_q1;
            t_o4 <= {t_o4[63:0], a};
        end
    end

    assign dut_o1 = t_q1 ^ f1;
    assign dut_o2 = t_q2 ^ f2;
    assign dut_o3 = t_q3;
    assign dut_o4 = t_o4 ^ {f4, 64'b0};

    fiapp_response_monitor #(
        .CYC_W  (CYC_W),
        .CNT_W  (CNT_W),
        .HIST_D (HIST_D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mon_a        (a),
        .mon_enable   (enable),
        .dut_o1       (dut_o1),
        .dut_o2       (dut_o2),
        .dut_o3       (dut_o3),
        .dut_o4       (dut_o4),
        .arm          (arm),
        .disarm       (disarm),
        .clr          (clr),
        .state_o      (state_o),
        .fault_o      (fault_o),
        .err_cnt_o    (err_cnt_o),
        .first_cyc_o  (first_cyc_o),
        .first_mask_o (first_mask_o),
        .hist_valid_o (hist_valid_o),
        .hist_ready_i (hist_ready),
        .hist_data_o  (hist_data_o),
        .hist_ovf_o   (hist_ovf_o)
    );

    typedef struct {
        string       tag;
        int          sig;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] hq[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sig);
        case (sig)
            SIG_STATE: return 64'(state_o);
            SIG_FAULT: return 64'(fault_o);
            SIG_ERR:   return 64'(err_cnt_o);
            SIG_FCYC:  return 64'(first_cyc_o);
            SIG_FMASK: return 64'(first_mask_o);
            SIG_HVLD:  return 64'(hist_valid_o);
            SIG_HOVF:  return 64'(hist_ovf_o);
            default:   return 64'(hist_data_o);
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sig, input logic [63:0] val);
        sb.push_back('{tag, sig, val});
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            check_eq(e.tag, observe(e.sig), e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            a      = 1'($urandom_range(0, 1));
            enable = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step(1);
        arm = 1'b0;
    endtask

    task automatic disarm_pulse();
        disarm = 1'b1;
        step(1);
        disarm = 1'b0;
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        expect_out("rst_state", SIG_STATE, 0);
        expect_out("rst_fault", SIG_FAULT, 0);
        expect_out("rst_err",   SIG_ERR,   0);
        expect_out("rst_fcyc",  SIG_FCYC,  0);
        expect_out("rst_fmask", SIG_FMASK, 0);
        expect_out("rst_hvld",  SIG_HVLD,  0);
        expect_out("rst_hovf",  SIG_HOVF,  0);
        drain();

        // Clean target for 200 cycles.
        arm_pulse();
        step(200);
        expect_out("clean_state", SIG_STATE, 1);
        expect_out("clean_fault", SIG_FAULT, 0);
        expect_out("clean_err",   SIG_ERR,   0);
        drain();

        // Single-cycle o1 fault at cycle 10.
        disarm_pulse();
        arm_pulse();
        step(10);
        f1 = 1'b1;
        step(1);
        f1 = 1'b0;
        step(2);
        expect_out("o1_state", SIG_STATE, 2);
        expect_out("o1_fault", SIG_FAULT, 1);
        expect_out("o1_fcyc",  SIG_FCYC,  10);
        expect_out("o1_fmask", SIG_FMASK, 3'b001);
        expect_out("o1_err",   SIG_ERR,   1);
        drain();

        // o4[64] flipped cycles 5..7, o2 also at cycle 6.
        disarm_pulse();
        arm_pulse();
        step(5);
        f4 = 1'b1;
        step(1);
        f2 = 1'b1;
        step(1);
        f2 = 1'b0;
        step(1);
        f4 = 1'b0;
        step(2);
        expect_out("o4_err",   SIG_ERR,   3);
        expect_out("o4_fmask", SIG_FMASK, 3'b100);
        expect_out("o4_fcyc",  SIG_FCYC,  5);
        drain();

        // Saturation of a 4-bit counter, then clr.
        disarm_pulse();
        arm_pulse();
        f2 = 1'b1;
        step(20);
        f2 = 1'b0;
        step(1);
        expect_out("sat_err",   SIG_ERR,   15);
        expect_out("sat_state", SIG_STATE, 2);
        drain();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        expect_out("clr_state", SIG_STATE, 1);
        expect_out("clr_fault", SIG_FAULT, 0);
        expect_out("clr_err",   SIG_ERR,   0);
        expect_out("clr_fcyc",  SIG_FCYC,  0);
        expect_out("clr_fmask", SIG_FMASK, 0);
        drain();

        // clr and mismatch in the same cycle: clr wins.
        f1 = 1'b1;
        step(1);
        f1 = 1'b0;
        clr = 1'b1;
        f1 = 1'b1;
        step(1);
        clr = 1'b0;
        f1 = 1'b0;
        expect_out("clrmm_state", SIG_STATE, 1);
        expect_out("clrmm_err",   SIG_ERR,   0);
        expect_out("clrmm_fault", SIG_FAULT, 0);
        drain();

        // disarm and arm together: disarm wins, fault info held.
        f1 = 1'b1;
        step(1);
        f1 = 1'b0;
        disarm = 1'b1;
        arm = 1'b1;
        step(1);
        disarm = 1'b0;
        arm = 1'b0;
        expect_out("disarm_state", SIG_STATE, 0);
        expect_out("disarm_fault", SIG_FAULT, 1);
        expect_out("disarm_err",   SIG_ERR,   1);
        drain();

        // Mismatches in IDLE are ignored.
        f1 = 1'b1;
        step(3);
        f1 = 1'b0;
        expect_out("idle_err",   SIG_ERR,   1);
        expect_out("idle_state", SIG_STATE, 0);
        drain();

        // Mismatch during the arm cycle is not counted.
        arm = 1'b1;
        f1 = 1'b1;
        step(1);
        arm = 1'b0;
        f1 = 1'b0;
        step(2);
        expect_out("armmm_state", SIG_STATE, 1);
        expect_out("armmm_err",   SIG_ERR,   0);
        expect_out("armmm_fault", SIG_FAULT, 0);
        drain();

        // Reset in the middle of FAULT.
        f2 = 1'b1;
        step(2);
        f2 = 1'b0;
        expect_out("pre_rst_state", SIG_STATE, 2);
        expect_out("pre_rst_fcyc",  SIG_FCYC,  2);
        expect_out("pre_rst_err",   SIG_ERR,   2);
        drain();
        #2 reset = 1'b1;
        #1;
        expect_out("mid_rst_state", SIG_STATE, 0);
        expect_out("mid_rst_fault", SIG_FAULT, 0);
        expect_out("mid_rst_err",   SIG_ERR,   0);
        expect_out("mid_rst_fcyc",  SIG_FCYC,  0);
        expect_out("mid_rst_fmask", SIG_FMASK, 0);
        expect_out("mid_rst_hvld",  SIG_HVLD,  0);
        drain();
        step(1);
        reset = 1'b0;
        step(1);
        expect_out("post_rst_state", SIG_STATE, 0);
        drain();

        // Six mismatches at cycles 2..7 with no pops.
        arm_pulse();
        step(2);
        f1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (hq.size() < HIST_D)
                hq.push_back(64'({32'(2 + k), 3'b001}));
            step(1);
        end
        f1 = 1'b0;
        step(1);
        expect_out("hist_err",   SIG_ERR,   6);
        expect_out("hist_state", SIG_STATE, 2);
`ifdef FIAPP_MON_HISTORY_EN
        expect_out("hist_ovf",  SIG_HOVF, 1);
        expect_out("hist_vld",  SIG_HVLD, 1);
        drain();
        hist_ready = 1'b1;
        while (hq.size() > 0) begin
            logic [63:0] e = hq.pop_front();
            check_eq("hist_vld_pop", 64'(hist_valid_o), 1);
            check_eq("hist_data", 64'(hist_data_o), e);
            step(1);
        end
        hist_ready = 1'b0;
        expect_out("hist_empty", SIG_HVLD, 0);
        drain();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        expect_out("hist_ovf_clr", SIG_HOVF, 0);
        drain();
`else
        hq.delete();
        hist_ready = 1'b1;
        step(1);
        expect_out("nohist_vld", SIG_HVLD, 0);
        expect_out("nohist_ovf", SIG_HOVF, 0);
        expect_out("nohist_dat", SIG_HDAT, 0);
        drain();
        hist_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
